// File: rtl/tt_um_hoene_led_pkg.sv
// Shared types and sizes for the smart-LED frame controller.
package tt_um_hoene_led_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FORWARD = 2'd2,
    ERROR   = 2'd3
  } led_state_t;

  localparam int FRAME_BITS = 25;
  localparam int PWM_WIDTH  = 8;
  localparam int CNT_WIDTH  = 5;

endpackage

// File: rtl/tt_um_hoene_frame_shifter.sv
// Capture datapath: MSB-first shift register, running parity and a saturating bit counter.
module tt_um_hoene_frame_shifter
  import tt_um_hoene_led_pkg::*;
#(
  parameter int DATA_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 shift,
  input  logic                 bit_in,
  output logic [CNT_WIDTH-1:0] count,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_ok
);

  logic parity_acc;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count      <= '0;
      data       <= '0;
      parity_acc <= 1'b0;
    end else if (shift) begin
      if (count != {CNT_WIDTH{1'b1}})
        count <= count + 1'b1;
      // Only data bits land in the register; the parity bit is judged, not stored.
      if (count < CNT_WIDTH'(DATA_BITS)) begin
        data       <= {data[DATA_BITS-2:0], bit_in};
        parity_acc <= parity_acc ^ bit_in;
      end
    end
  end

  // Even parity across data plus the incoming parity bit.
  assign parity_ok = ~(parity_acc ^ bit_in);

endmodule

// File: rtl/tt_um_hoene_led_frame_controller.sv
// Frame controller: captures this LED's RGB frame after sync, then forwards the rest downstream.
module tt_um_hoene_led_frame_controller
  import tt_um_hoene_led_pkg::*;
#(
  parameter int DATA_BITS = 24,
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_sync,
  input  logic                 in_clk,
  input  logic                 in_data,
  output logic [PWM_WIDTH-1:0] pwm_r,
  output logic [PWM_WIDTH-1:0] pwm_g,
  output logic [PWM_WIDTH-1:0] pwm_b,
  output logic                 pwm_load,
  output logic                 fwd_clk,
  output logic                 fwd_data,
  output logic                 frame_error,
  output logic [1:0]           state
);

  led_state_t           st;
  logic [CNT_WIDTH-1:0] count;
  logic [DATA_BITS-1:0] data;
  logic                 parity_ok;
  logic                 shift;
  logic                 clear;

  // A strobe coinciding with sync loss is dropped, so shifting requires sync.
  assign shift = (st == CAPTURE) && in_sync && in_clk;
  assign clear = (st == IDLE);

  tt_um_hoene_frame_shifter #(
    .DATA_BITS(DATA_BITS)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .shift    (shift),
    .bit_in   (in_data),
    .count    (count),
    .data     (data),
    .parity_ok(parity_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      pwm_r       <= '0;
      pwm_g       <= '0;
      pwm_b       <= '0;
      pwm_load    <= 1'b0;
      fwd_clk     <= 1'b0;
      fwd_data    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      pwm_load <= 1'b0;
      fwd_clk  <= 1'b0;
      fwd_data <= 1'b0;
      case (st)
        IDLE: begin
          if (in_sync) begin
            st          <= CAPTURE;
            frame_error <= 1'b0;
          end
        end
        CAPTURE: begin
          if (!in_sync) begin
            st <= IDLE;
            if (count != '0)
              frame_error <= 1'b1;
          end else if (in_clk && count == CNT_WIDTH'(DATA_BITS)) begin
            if (parity_ok) begin
              pwm_r    <= data[3*PWM_WIDTH-1:2*PWM_WIDTH];
              pwm_g    <= data[2*PWM_WIDTH-1:PWM_WIDTH];
              pwm_b    <= data[PWM_WIDTH-1:0];
              pwm_load <= 1'b1;
              st       <= FORWARD;
            end else begin
              frame_error <= 1'b1;
              st          <= ERROR;
            end
          end
        end
        FORWARD: begin
          if (!in_sync) begin
            st <= IDLE;
          end else if (in_clk) begin
            fwd_clk  <= 1'b1;
            fwd_data <= in_data;
          end
        end
        ERROR: begin
          if (!in_sync)
            st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_tt_um_hoene_led_frame_controller.sv
// Directed plus randomized bench for the LED frame controller against a frame-level model.
module tb_tt_um_hoene_led_frame_controller;

  logic       clk = 1'b0;
  logic       rst, in_sync, in_clk, in_data;
  logic [7:0] pwm_r, pwm_g, pwm_b;
  logic       pwm_load, fwd_clk, fwd_data, frame_error;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the colour the LED should currently show.
  logic [23:0] exp_rgb = 24'h0;

  tt_um_hoene_led_frame_controller dut (
    .clk        (clk),
    .rst        (rst),
    .in_sync    (in_sync),
    .in_clk     (in_clk),
    .in_data    (in_data),
    .pwm_r      (pwm_r),
    .pwm_g      (pwm_g),
    .pwm_b      (pwm_b),
    .pwm_load   (pwm_load),
    .fwd_clk    (fwd_clk),
    .fwd_data   (fwd_data),
    .frame_error(frame_error),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pwm(input string tag);
    chk({tag, "_pwm"}, {8'h0, pwm_r, pwm_g, pwm_b}, {8'h0, exp_rgb});
  endtask

  task automatic gap(input int max_gap);
    int n;
    n = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    in_clk = 1'b0;
    repeat (n) tick();
  endtask

  task automatic start_sync();
    in_sync = 1'b1;
    in_clk  = 1'b1;
    in_data = 1'b1;
    tick();
    in_clk = 1'b0;
    chk("sync_state", 32'(state), 32'd1);
    chk("sync_err", 32'(frame_error), 32'd0);
    chk("sync_fwd", 32'(fwd_clk), 32'd0);
  endtask

  task automatic send_partial(input logic [23:0] rgb, input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      gap(max_gap);
      in_clk  = 1'b1;
      in_data = rgb[23-i];
      tick();
      in_clk = 1'b0;
      chk("cap_state", 32'(state), 32'd1);
      chk("cap_load", 32'(pwm_load), 32'd0);
    end
  endtask

  task automatic send_frame(input logic [23:0] rgb, input logic par, input int max_gap);
    bit good;
    good = ((($countones(rgb) + int'(par)) % 2) == 0);
    send_partial(rgb, 24, max_gap);
    gap(max_gap);
    in_clk  = 1'b1;
    in_data = par;
    tick();
    in_clk = 1'b0;
    if (good) exp_rgb = rgb;
    chk("par_load", 32'(pwm_load), good ? 32'd1 : 32'd0);
    chk("par_state", 32'(state), good ? 32'd2 : 32'd3);
    chk("par_err", 32'(frame_error), good ? 32'd0 : 32'd1);
    chk("par_fwd", 32'(fwd_clk), 32'd0);
    chk_pwm("par");
    tick();
    chk("load_pulse", 32'(pwm_load), 32'd0);
  endtask

  task automatic forward_bits(input logic [63:0] bits, input int n, input int max_gap);
    for (int i = n - 1; i >= 0; i--) begin
      gap(max_gap);
      in_clk  = 1'b1;
      in_data = bits[i];
      tick();
      in_clk = 1'b0;
      chk("fwd_clk", 32'(fwd_clk), 32'd1);
      chk("fwd_data", 32'(fwd_data), 32'(bits[i]));
      chk("fwd_load", 32'(pwm_load), 32'd0);
    end
    tick();
    chk("fwd_idle", 32'(fwd_clk), 32'd0);
    chk_pwm("fwd");
  endtask

  task automatic drop_sync(input logic exp_err);
    in_sync = 1'b0;
    in_clk  = 1'b0;
    tick();
    chk("drop_state", 32'(state), 32'd0);
    chk("drop_err", 32'(frame_error), 32'(exp_err));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {pwm_r, pwm_g, pwm_b, pwm_load, fwd_clk, fwd_data, frame_error},
        32'd0);
    chk({tag, "_state"}, 32'(state), 32'd0);
  endtask

  initial begin
    logic [63:0] fb;
    logic [23:0] rgb;
    int          mode;
    int          n;

    rst = 1'b1; in_sync = 1'b0; in_clk = 1'b0; in_data = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk_all_zero("post_reset");

    // Good frame 12/34/56 with even parity bit 1, back-to-back strobes.
    start_sync();
    send_frame(24'h123456, 1'b1, 0);

    // Forward a second frame's worth of bits, back-to-back.
    fb = {39'h0, 24'hA5C3F0, 1'b0};
    forward_bits(fb, 25, 0);

    // Strobe coinciding with sync loss in FORWARD is dropped.
    in_sync = 1'b0; in_clk = 1'b1; in_data = 1'b1;
    tick();
    in_clk = 1'b0;
    chk("simul_fwd", 32'(fwd_clk), 32'd0);
    chk("simul_state", 32'(state), 32'd0);
    chk("simul_err", 32'(frame_error), 32'd0);

    // Parity error: no commit, no forwarding while in ERROR.
    start_sync();
    send_frame(24'h123456, 1'b0, 0);
    fb = 64'h5;
    for (int i = 0; i < 3; i++) begin
      in_clk = 1'b1; in_data = fb[i];
      tick();
      in_clk = 1'b0;
      chk("err_nofwd", 32'(fwd_clk), 32'd0);
      chk("err_state", 32'(state), 32'd3);
    end
    chk_pwm("err");
    drop_sync(1'b1);

    // Truncated frame after 10 bits, then recovery.
    start_sync();
    send_partial(24'hABCDEF, 10, 0);
    drop_sync(1'b1);
    start_sync();
    send_frame(24'h0F1E2D, ^24'h0F1E2D, 1);
    drop_sync(1'b0);

    // Reset after bit 12, then a clean frame.
    start_sync();
    send_partial(24'h777777, 12, 0);
    rst = 1'b1; in_sync = 1'b0;
    tick();
    exp_rgb = 24'h0;
    chk_all_zero("mid_reset");
    rst = 1'b0;
    tick();
    chk_all_zero("after_reset");
    start_sync();
    send_frame(24'hFF0000, 1'b0, 0);
    chk("red_r", 32'(pwm_r), 32'hFF);
    drop_sync(1'b0);

    // Randomized frames: good, bad parity, or truncated, with random strobe gaps.
    for (int it = 0; it < 24; it++) begin
      rgb  = 24'($urandom);
      mode = $urandom_range(0, 3);
      start_sync();
      if (mode == 0) begin
        send_frame(rgb, ~(^rgb), 2);
        drop_sync(1'b1);
      end else if (mode == 1) begin
        n = $urandom_range(0, 24);
        send_partial(rgb, n, 2);
        drop_sync(n > 0);
        chk_pwm("trunc");
      end else begin
        send_frame(rgb, ^rgb, 2);
        fb = {$urandom, $urandom};
        forward_bits(fb, $urandom_range(1, 40), 2);
        drop_sync(1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
